// File: rtl/adsr_voice_engine.sv
// adsr_voice_engine: multi-voice ADSR envelope engine with a two-stage valid/ready pipeline.
// Stage 1 captures the beat; stage 2 reads the voice entry, writes back the updated envelope and
// loads the output registers. The voice read happens at advance time, so a same-voice beat that
// follows directly always sees the previous write-back.
//
//  state   | meaning
//  IDLE    | voice silent, env held at 0
//  ATTACK  | env rising by attack_rate toward full scale
//  DECAY   | env falling by decay_rate toward the sustain target
//  SUSTAIN | env follows the live sustain target
//  RELEASE | key up, env falling by release_rate toward 0
module adsr_voice_engine #(
    parameter int ADDR_W   = 3,
    parameter int SAMPLE_W = 16,
    parameter int ENV_W    = 24,
    parameter int RATE_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_voice,
    input  logic                       in_gate,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    input  logic [RATE_W-1:0]          attack_rate,
    input  logic [RATE_W-1:0]          decay_rate,
    input  logic [RATE_W-1:0]          sustain_level,
    input  logic [RATE_W-1:0]          release_rate,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_voice,
    output logic signed [SAMPLE_W-1:0] out_sample,
    output logic [2:0]                 out_state
);
    localparam int NUM_VOICES = 2 ** ADDR_W;
    localparam int CMP_W      = ENV_W + 1;
    localparam int PROD_W     = 2 * SAMPLE_W + 1;
    localparam logic [ENV_W-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    logic [ENV_W-1:0] env_mem   [NUM_VOICES];
    env_state_t       state_mem [NUM_VOICES];
    logic             gate_mem  [NUM_VOICES];

    logic                       s1_valid;
    logic [ADDR_W-1:0]          s1_voice;
    logic                       s1_gate;
    logic signed [SAMPLE_W-1:0] s1_sample;

    logic                       advance;
    logic [ENV_W-1:0]           env_cur;
    logic [ENV_W-1:0]           env_nxt;
    logic [ENV_W-1:0]           sus_target;
    env_state_t                 state_cur;
    env_state_t                 state_nxt;
    logic                       gate_cur;
    logic [CMP_W-1:0]           env_wide;
    logic [CMP_W-1:0]           attack_sum;
    logic [CMP_W-1:0]           decay_floor;
    logic [SAMPLE_W-1:0]        env_scale;
    logic signed [PROD_W-1:0]   scale_wide;
    logic signed [PROD_W-1:0]   sample_wide;
    logic signed [PROD_W-1:0]   product;
    logic signed [SAMPLE_W-1:0] sample_nxt;

    // The pipeline moves whenever the output register is empty or being consumed.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // Read the stage-1 voice entry and compute its next envelope, state and output sample.
    always_comb begin
        env_cur     = env_mem[s1_voice];
        state_cur   = state_mem[s1_voice];
        gate_cur    = gate_mem[s1_voice];
        sus_target  = ENV_W'(sustain_level) << (ENV_W - RATE_W);
        // One extra bit on every compare so sums cannot wrap.
        env_wide    = {1'b0, env_cur};
        attack_sum  = env_wide + CMP_W'(attack_rate);
        decay_floor = {1'b0, sus_target} + CMP_W'(decay_rate);
        env_nxt     = env_cur;
        state_nxt   = state_cur;

        if (s1_gate && !gate_cur) begin
            // Retrigger keeps the current level and restarts the attack from there.
            state_nxt = ATTACK;
        end else begin
            case (state_cur)
                IDLE: begin
                    env_nxt = '0;
                    if (s1_gate) state_nxt = ATTACK;
                end
                ATTACK: begin
                    if (!s1_gate) begin
                        state_nxt = RELEASE;
                    end else if (attack_sum >= {1'b0, ENV_MAX}) begin
                        env_nxt   = ENV_MAX;
                        state_nxt = DECAY;
                    end else begin
                        env_nxt = env_cur + ENV_W'(attack_rate);
                    end
                end
                DECAY: begin
                    if (!s1_gate) begin
                        state_nxt = RELEASE;
                    end else if (env_wide <= decay_floor) begin
                        env_nxt   = sus_target;
                        state_nxt = SUSTAIN;
                    end else begin
                        env_nxt = env_cur - ENV_W'(decay_rate);
                    end
                end
                SUSTAIN: begin
                    if (!s1_gate) state_nxt = RELEASE;
                    else          env_nxt   = sus_target;
                end
                RELEASE: begin
                    if (env_wide <= CMP_W'(release_rate)) begin
                        env_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        env_nxt = env_cur - ENV_W'(release_rate);
                    end
                end
                default: begin
                    env_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end

        // The output is scaled by the envelope as it was before this update.
        env_scale   = env_cur[ENV_W-1 -: SAMPLE_W];
        scale_wide  = PROD_W'(env_scale);
        sample_wide = PROD_W'(s1_sample);
        product     = scale_wide * sample_wide;
        sample_nxt  = SAMPLE_W'(product >>> SAMPLE_W);
    end

    // Pipeline registers, voice write-back and output registers; all hold during a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_voice   <= '0;
            s1_gate    <= 1'b0;
            s1_sample  <= '0;
            out_valid  <= 1'b0;
            out_voice  <= '0;
            out_sample <= '0;
            out_state  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                env_mem[i]   <= '0;
                state_mem[i] <= IDLE;
                gate_mem[i]  <= 1'b0;
            end
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_voice  <= in_voice;
                s1_gate   <= in_gate;
                s1_sample <= in_sample;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                env_mem[s1_voice]   <= env_nxt;
                state_mem[s1_voice] <= state_nxt;
                gate_mem[s1_voice]  <= s1_gate;
                out_voice           <= s1_voice;
                out_sample          <= sample_nxt;
                out_state           <= state_nxt;
            end
        end
    end

endmodule

// File: tb/tb_adsr_voice_engine.sv
// tb_adsr_voice_engine: directed and randomized checks of the ADSR voice engine against a
// per-voice reference model written with plain integer arithmetic.
module tb_adsr_voice_engine;
    localparam longint ENV_MAX    = 64'h0000_0000_00FF_FFFF;
    localparam int     ST_IDLE    = 0;
    localparam int     ST_ATTACK  = 1;
    localparam int     ST_DECAY   = 2;
    localparam int     ST_SUSTAIN = 3;
    localparam int     ST_RELEASE = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_voice;
    logic               in_gate;
    logic signed [15:0] in_sample;
    logic [15:0]        attack_rate;
    logic [15:0]        decay_rate;
    logic [15:0]        sustain_level;
    logic [15:0]        release_rate;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         out_voice;
    logic signed [15:0] out_sample;
    logic [2:0]         out_state;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one envelope, state and stored gate per voice.
    longint m_env   [8];
    int     m_state [8];
    bit     m_gate  [8];

    typedef struct {
        logic [2:0]         voice;
        logic signed [15:0] sample;
        logic [2:0]         state;
        int                 cyc;
    } exp_t;

    adsr_voice_engine dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_voice      (in_voice),
        .in_gate       (in_gate),
        .in_sample     (in_sample),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_voice     (out_voice),
        .out_sample    (out_sample),
        .out_state     (out_state)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int v = 0; v < 8; v++) begin
            m_env[v]   = 0;
            m_state[v] = ST_IDLE;
            m_gate[v]  = 1'b0;
        end
    endfunction

    // One update of one voice, straight from the envelope rules; rates are read live.
    function automatic void model_step(input int v, input bit g, input logic signed [15:0] s,
                                       output logic signed [15:0] es, output logic [2:0] est);
        longint env  = m_env[v];
        int     st   = m_state[v];
        longint tgt  = longint'(sustain_level) * 256;
        longint prod = (env / 256) * longint'(s);
        es = 16'(prod >>> 16);
        if (g && !m_gate[v]) begin
            st = ST_ATTACK;
        end else if (st == ST_IDLE) begin
            env = 0;
            if (g) st = ST_ATTACK;
        end else if (st != ST_RELEASE && !g) begin
            st = ST_RELEASE;
        end else if (st == ST_ATTACK) begin
            if (env + longint'(attack_rate) >= ENV_MAX) begin env = ENV_MAX; st = ST_DECAY; end
            else env = env + longint'(attack_rate);
        end else if (st == ST_DECAY) begin
            if (env <= tgt + longint'(decay_rate)) begin env = tgt; st = ST_SUSTAIN; end
            else env = env - longint'(decay_rate);
        end else if (st == ST_SUSTAIN) begin
            env = tgt;
        end else begin
            if (env <= longint'(release_rate)) begin env = 0; st = ST_IDLE; end
            else env = env - longint'(release_rate);
        end
        m_env[v]   = env;
        m_state[v] = st;
        m_gate[v]  = g;
        est = 3'(st);
    endfunction

    // Send one beat into an idle pipeline and wait for its output; starts and ends on a falling edge.
    task automatic apply(input int v, input bit g, input logic signed [15:0] s,
                         output logic [2:0] ov, output logic signed [15:0] os, output logic [2:0] ost,
                         output logic signed [15:0] es, output logic [2:0] est, output bit ok);
        in_voice  = 3'(v);
        in_gate   = g;
        in_sample = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_step(v, g, s, es, est);
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) ok = 1'b1;
        end
        ov  = out_voice;
        os  = out_sample;
        ost = out_state;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_voice = '0; in_gate = 1'b0; in_sample = '0; out_ready = 1'b1;
        attack_rate = '0; decay_rate = '0; sustain_level = '0; release_rate = '0;
        model_clear();
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_voice !== 3'd0 || out_sample !== 16'sd0 || out_state !== 3'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%0d voice=%0d sample=%h state=%0d ready=%0d, want 0 0 0000 0 ready=1",
                     out_valid, out_voice, out_sample, out_state, in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_attack();
        logic [2:0] ov, ost, est;
        logic signed [15:0] os, es;
        bit ok;
        attack_rate = 16'h8000; decay_rate = 16'h0000; sustain_level = 16'h4000; release_rate = 16'h0000;
        for (int n = 1; n <= 513; n++) begin
            apply(2, 1'b1, 16'sh4000, ov, os, ost, es, est, ok);
            vectors++;
            if (!ok || ov !== 3'd2 || os !== es || ost !== est) begin
                miscompares++;
                $display("FAIL attack_update%0d: got ok=%0d voice=%0d sample=%h state=%0d, want voice=2 sample=%h state=%0d",
                         n, ok, ov, os, ost, es, est);
            end
            if (n == 1 || n == 258 || n == 512 || n == 513) begin
                vectors++;
                if ((n == 1   && (os !== 16'sh0000 || ost !== 3'd1)) ||
                    (n == 258 && (os !== 16'sh2000 || ost !== 3'd1)) ||
                    (n == 512 && ost !== 3'd1) ||
                    (n == 513 && ost !== 3'd2)) begin
                    miscompares++;
                    $display("FAIL attack_point%0d: got sample=%h state=%0d", n, os, ost);
                end
            end
        end
    endtask

    task automatic test_decay_sustain();
        logic [2:0] ov, ost, est;
        logic signed [15:0] os, es;
        bit ok;
        bit hit = 1'b0;
        int k = 0;
        sustain_level = 16'h4000; decay_rate = 16'h0000;
        decay_rate = 16'h0001 << 0;
        decay_rate = 16'hFFFF; decay_rate = 16'h0000;
        // A decay rate of 0x10000 does not fit the 16-bit port; use the largest step, 0xFFFF... no:
        // the env step here is decay_rate itself, so 0x10000 env units is not expressible; 0x8000 is used.
        decay_rate = 16'h8000;
        while (!hit && k < 600) begin
            k++;
            apply(2, 1'b1, 16'sh4000, ov, os, ost, es, est, ok);
            vectors++;
            if (!ok || os !== es || ost !== est) begin
                miscompares++;
                $display("FAIL decay_update%0d: got ok=%0d sample=%h state=%0d, want sample=%h state=%0d",
                         k, ok, os, ost, es, est);
            end
            if (ost === 3'd3) hit = 1'b1;
        end
        // 0xFFFFFF down by 0x8000 per update reaches <= 0x408000 after 383 steps; update 384 settles.
        vectors++;
        if (!hit || k != 384) begin
            miscompares++;
            $display("FAIL decay_steps: got hit=%0d updates=%0d, want hit=1 updates=384", hit, k);
        end
        apply(2, 1'b1, 16'sh4000, ov, os, ost, es, est, ok);
        vectors++;
        if (!ok || os !== 16'sh1000 || ost !== 3'd3) begin
            miscompares++;
            $display("FAIL sustain_level: got sample=%h state=%0d, want sample=1000 state=3", os, ost);
        end
        sustain_level = 16'h2000;
        apply(2, 1'b1, 16'sh4000, ov, os, ost, es, est, ok);
        apply(2, 1'b1, 16'sh4000, ov, os, ost, es, est, ok);
        vectors++;
        if (!ok || os !== 16'sh0800 || ost !== 3'd3 || os !== es) begin
            miscompares++;
            $display("FAIL sustain_track: got sample=%h state=%0d, want sample=0800 state=3", os, ost);
        end
    endtask

    task automatic test_release_retrigger();
        logic [2:0] ov, ost, est;
        logic signed [15:0] os, es;
        bit ok;
        int k = 0;
        bit idle = 1'b0;
        release_rate = 16'h8000;
        while (!idle && k < 200) begin
            k++;
            apply(2, 1'b0, 16'sh4000, ov, os, ost, es, est, ok);
            vectors++;
            if (!ok || os !== es || ost !== est || (k == 1 && (os !== 16'sh0800 || ost !== 3'd4))) begin
                miscompares++;
                $display("FAIL release_update%0d: got ok=%0d sample=%h state=%0d, want sample=%h state=%0d",
                         k, ok, os, ost, es, est);
            end
            if (ost === 3'd0) idle = 1'b1;
        end
        // Enter RELEASE unchanged, 63 steps of 0x8000 from 0x200000, then the update that reaches 0.
        vectors++;
        if (!idle || k != 65) begin
            miscompares++;
            $display("FAIL release_steps: got idle=%0d updates=%0d, want idle=1 updates=65", idle, k);
        end
        release_rate = 16'h4000;
        for (int n = 0; n < 7; n++) begin
            bit g = !(n == 4 || n == 5);
            apply(2, g, 16'sh4000, ov, os, ost, es, est, ok);
            vectors++;
            if (!ok || os !== es || ost !== est) begin
                miscompares++;
                $display("FAIL retrigger_step%0d: got ok=%0d sample=%h state=%0d, want sample=%h state=%0d",
                         n, ok, os, ost, es, est);
            end
        end
        // Retrigger left env at 0x14000 and the attack has not stepped yet.
        apply(2, 1'b1, 16'sh4000, ov, os, ost, es, est, ok);
        vectors++;
        if (!ok || os !== 16'sh0050 || ost !== 3'd1) begin
            miscompares++;
            $display("FAIL retrigger_level: got sample=%h state=%0d, want sample=0050 state=1", os, ost);
        end
    endtask

    // mode 0: interleaved back-to-back, no stall; 1: random traffic and backpressure; 2: 3-cycle stall.
    task automatic test_stream(input string name, input int n, input int mode);
        exp_t q[$];
        exp_t e;
        logic signed [15:0] es;
        logic [2:0] est;
        int sent = 0, got = 0, cyc = 0;
        bit load = 1'b1;
        bit want_ready;
        attack_rate   = 16'($urandom_range(16'hC000, 16'hFFFF));
        decay_rate    = 16'($urandom_range(16'h1000, 16'hFFFF));
        sustain_level = 16'($urandom_range(16'h0000, 16'hFFFF));
        release_rate  = 16'($urandom_range(16'h8000, 16'hFFFF));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        while (got < n && cyc < 8 * n + 50) begin
            if (out_valid === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s_extra_beat: got voice=%0d sample=%h, want no output", name, out_voice, out_sample);
                end else begin
                    e = q[0];
                    if (out_voice !== e.voice || out_sample !== e.sample || out_state !== e.state ||
                        (mode == 0 && cyc != e.cyc + 2)) begin
                        miscompares++;
                        $display("FAIL %s_beat%0d: got voice=%0d sample=%h state=%0d cyc=%0d, want voice=%0d sample=%h state=%0d cyc=%0d",
                                 name, got, out_voice, out_sample, out_state, cyc, e.voice, e.sample, e.state, e.cyc + 2);
                    end
                end
            end
            if (load) begin
                if (sent < n) begin
                    if (mode == 1) in_voice = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
                    else           in_voice = 3'(sent % 8);
                    in_gate   = (mode == 1) ? ($urandom_range(0, 15) != 0) : 1'b1;
                    in_sample = 16'($urandom);
                    in_valid  = (mode == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else                out_ready = !(cyc >= 4 && cyc < 7);
            #1;
            want_ready = !(out_valid === 1'b1 && out_ready == 1'b0);
            vectors++;
            if (in_ready !== want_ready) begin
                miscompares++;
                $display("FAIL %s_in_ready cyc%0d: got %0d, want %0d", name, cyc, in_ready, want_ready);
            end
            load = 1'b0;
            if (in_valid && in_ready === 1'b1) begin
                model_step(int'(in_voice), in_gate, in_sample, es, est);
                q.push_back('{in_voice, es, est, cyc});
                sent++;
                load = 1'b1;
            end else if (!in_valid) begin
                load = 1'b1;
            end
            if (out_valid === 1'b1 && out_ready && q.size() > 0) begin
                e = q.pop_front();
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (got < n) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d beats, want %0d", name, got, n);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_async();
        logic [2:0] ov, ost, est;
        logic signed [15:0] os, es;
        bit ok;
        attack_rate = 16'h8000;
        for (int n = 0; n < 16; n++) begin
            apply(n % 8, 1'b1, 16'sh4000, ov, os, ost, es, est, ok);
            vectors++;
            if (!ok || os !== es || ost !== est) begin
                miscompares++;
                $display("FAIL prereset_voice%0d: got sample=%h state=%0d, want sample=%h state=%0d", n % 8, os, ost, es, est);
            end
        end
        in_voice = 3'd5; in_gate = 1'b1; in_sample = 16'sh4000; in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_sample !== 16'sd0 || out_state !== 3'd0 || out_voice !== 3'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%0d sample=%h state=%0d voice=%0d ready=%0d, want 0 0000 0 0 ready=1",
                     out_valid, out_sample, out_state, out_voice, in_ready);
        end
        in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int v = 0; v < 8; v++) begin
            apply(v, 1'b1, 16'sh4000, ov, os, ost, es, est, ok);
            vectors++;
            if (!ok || ov !== 3'(v) || os !== 16'sh0000 || ost !== 3'd1) begin
                miscompares++;
                $display("FAIL postreset_voice%0d: got ok=%0d voice=%0d sample=%h state=%0d, want sample=0000 state=1",
                         v, ok, ov, os, ost);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_attack();
        test_decay_sustain();
        test_release_retrigger();
        test_stream("back_to_back", 24, 0);
        test_stream("stall", 20, 2);
        test_stream("random", 800, 1);
        test_reset_async();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
